lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Load/store sequencer between the core's execute stage and the data port (port 2 plus write port) of the byte-addressed unified memory. Accepts one load or store request at a time and issues word-aligned memory accesses with byte enables. Splits word-crossing misaligned accesses into two aligned accesses. Returns sign- or zero-extended load data with a one-cycle response pulse.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data width; fixed at 32, any other value is a configuration error
ALLOW_MISALIGNED, 1, 1 = split word-crossing accesses; 0 = reject them with rsp_err

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  load zero-extends when 1
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, right-aligned
rsp_valid  out  1  one-cycle completion pulse (loads and stores)
rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
rsp_err  out  1  valid with rsp_valid; illegal size or rejected misalign
mem_addr  out  ADDR_WIDTH  word-aligned read address (to addr2)
mem_rd_data  in  DATA_WIDTH  combinational read data (rd_data2)
mem_wr_en  out  1  write strobe
mem_wr_addr  out  ADDR_WIDTH  word-aligned write address
mem_wr_data  out  DATA_WIDTH  lane-shifted write data
mem_byte_en  out  4  byte lane enables

Behaviour:
- States: IDLE, ACC1, ACC2, RESP.
- Reset (async, rst_n=0): state=IDLE, all request registers=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_wr_en=0, mem_byte_en=0, mem_addr=0, mem_wr_addr=0.
- Reset mid-operation: the transaction is abandoned with no response. If ACC1 of a split store already completed, that first half stays written.
- Request handshake: accepted on a rising edge with req_valid && req_ready. Latch we, size, unsigned, addr, wdata. Compute off=addr[1:0], nbytes=1/2/4 and cross=(off+nbytes>4).
- IDLE -> RESP with err=1 if size==11, or if cross && !ALLOW_MISALIGNED. No memory access in this case. Otherwise IDLE -> ACC1.
- Lane math:
  - m8 = ({4'b0, mask} << off), where mask = 0001, 0011 or 1111.
  - d64 = ({32'b0, wdata} << 8*off).
  - ACC1 uses word addr W0={addr[AW-1:2],2'b00}, byte_en=m8[3:0], wr_data=d64[31:0].
  - ACC2 uses W1=W0+4, wrapping modulo 2^ADDR_WIDTH, with byte_en=m8[7:4] and wr_data=d64[63:32].
- ACC1 and ACC2:
  - mem_addr and mem_wr_addr = current word address.
  - mem_wr_en = latched we.
  - mem_byte_en = lane mask, also driven on loads.
  - Loads capture mem_rd_data into buf_lo (ACC1) or buf_hi (ACC2) at the end of the cycle.
  - ACC1 -> ACC2 if cross, else -> RESP. ACC2 -> RESP.
- Outside ACC1/ACC2: mem_wr_en=0 and mem_byte_en=0.
- RESP:
  - rsp_valid=1 for exactly one cycle, then -> IDLE.
  - Load data: raw = ({buf_hi, buf_lo} >> 8*off). Extract the low nbytes. Sign-extend from the top bit unless unsigned; word loads ignore unsigned.
  - Store or error: rsp_rdata=0.
- Latency, accept edge to rsp_valid: aligned or in-word = 2 cycles; split = 3 cycles; error = 1 cycle. Back-to-back throughput is one request per 3 or 4 cycles.
- req_valid while !req_ready: ignored; the requester must hold the request.

Test Plan:
- Reset: assert rst_n=0 mid-ACC1 of a store -> all outputs 0 immediately; state IDLE; no further mem_wr_en.
- Aligned word: store 0xDEADBEEF @0x100, then load word @0x100 -> store issues byte_en=1111 at 0x100; load returns rsp_rdata=0xDEADBEEF 2 cycles after accept, rsp_err=0.
- Sub-word sign: store byte 0x80 @0x203 (byte_en=1000, wr_data=0x80000000) -> load byte signed @0x203 returns 0xFFFFFF80; unsigned returns 0x00000080.
- Split: store word 0x11223344 @0x101 -> ACC1 W=0x100, be=1110, data=0x22334400; ACC2 W=0x104, be=0001, data=0x00000011. Load word @0x101 returns 0x11223344 3 cycles after accept.
- Wrap: half store 0xABCD @0xFFFFFFFF -> ACC1 W=0xFFFFFFFC, be=1000; ACC2 W=0x00000000, be=0001.
- Errors: size=11, and the split case with ALLOW_MISALIGNED=0 -> rsp_valid with rsp_err=1 one cycle after accept, rsp_rdata=0, mem_wr_en never asserted.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer: one request at a time, word-aligned accesses with byte enables,
// word-crossing accesses split in two, extended load data returned with a response pulse.
module lsu_mem_ctrl #(
   parameter int unsigned ADDR_WIDTH       = 32,
   parameter int unsigned DATA_WIDTH       = 32,
   parameter bit          ALLOW_MISALIGNED = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic                  mem_wr_en,
   output logic [ADDR_WIDTH-1:0] mem_wr_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   output logic [3:0]            mem_byte_en
);

   typedef enum logic [1:0] {StIdle, StAcc1, StAcc2, StResp} state_e;

   state_e                state_q;
   logic                  we_q;
   logic [1:0]            size_q;
   logic                  uns_q;
   logic [1:0]            off_q;
   logic                  cross_q;
   logic [ADDR_WIDTH-1:0] w1_q;
   logic [3:0]            be_hi_q;
   logic [31:0]           wd_hi_q;
   logic [31:0]           buf_lo_q;
   logic [23:0]           buf_hi_q;

   logic [1:0]            req_off;
   logic [3:0]            req_mask;
   logic [2:0]            req_nbytes;
   logic [2:0]            req_end;
   logic                  req_cross;
   logic                  req_bad;
   logic [7:0]            req_m8;
   logic [63:0]           req_d64;
   logic [ADDR_WIDTH-1:0] req_w0;

   logic [31:0]           ld_lo;
   logic [23:0]           ld_hi;
   logic [31:0]           ld_raw;
   logic [31:0]           ld_ext;
   logic [31:0]           rsp_data_n;

   assign req_ready = (state_q == StIdle);

   always_comb begin
      req_mask   = 4'b1111;
      req_nbytes = 3'd4;
      case (req_size)
         2'b00:   begin req_mask = 4'b0001; req_nbytes = 3'd1; end
         2'b01:   begin req_mask = 4'b0011; req_nbytes = 3'd2; end
         default: begin req_mask = 4'b1111; req_nbytes = 3'd4; end
      endcase
   end

   assign req_off   = req_addr[1:0];
   assign req_end   = {1'b0, req_off} + req_nbytes;
   assign req_cross = (req_end > 3'd4);
   assign req_bad   = (req_size == 2'b11) || (req_cross && !ALLOW_MISALIGNED);
   assign req_m8    = {4'b0000, req_mask} << req_off;
   assign req_d64   = {32'b0, req_wdata} << {req_off, 3'b000};
   assign req_w0    = {req_addr[ADDR_WIDTH-1:2], 2'b00};

   // Buffers as they will look after this edge, so the response can be registered in the same edge
   assign ld_lo = (state_q == StAcc1) ? mem_rd_data : buf_lo_q;
   assign ld_hi = (state_q == StAcc2) ? mem_rd_data[23:0] : buf_hi_q;

   always_comb begin
      ld_raw = ld_lo;
      case (off_q)
         2'd0:    ld_raw = ld_lo;
         2'd1:    ld_raw = {ld_hi[7:0],  ld_lo[31:8]};
         2'd2:    ld_raw = {ld_hi[15:0], ld_lo[31:16]};
         default: ld_raw = {ld_hi[23:0], ld_lo[31:24]};
      endcase
   end

   always_comb begin
      ld_ext = ld_raw;
      case (size_q)
         2'b00:   ld_ext = uns_q ? {24'b0, ld_raw[7:0]}  : {{24{ld_raw[7]}}, ld_raw[7:0]};
         2'b01:   ld_ext = uns_q ? {16'b0, ld_raw[15:0]} : {{16{ld_raw[15]}}, ld_raw[15:0]};
         default: ld_ext = ld_raw;
      endcase
   end

   assign rsp_data_n = we_q ? 32'b0 : ld_ext;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         we_q        <= 1'b0;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         off_q       <= 2'b00;
         cross_q     <= 1'b0;
         w1_q        <= '0;
         be_hi_q     <= 4'b0;
         wd_hi_q     <= 32'b0;
         buf_lo_q    <= 32'b0;
         buf_hi_q    <= 24'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         mem_addr    <= '0;
         mem_wr_addr <= '0;
         mem_wr_data <= '0;
         mem_wr_en   <= 1'b0;
         mem_byte_en <= 4'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  size_q  <= req_size;
                  uns_q   <= req_unsigned;
                  off_q   <= req_off;
                  cross_q <= req_cross;
                  w1_q    <= req_w0 + {{(ADDR_WIDTH-3){1'b0}}, 3'd4};
                  be_hi_q <= req_m8[7:4];
                  wd_hi_q <= req_d64[63:32];
                  if (req_bad) begin
                     state_q   <= StResp;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end else begin
                     state_q     <= StAcc1;
                     mem_addr    <= req_w0;
                     mem_wr_addr <= req_w0;
                     mem_wr_en   <= req_we;
                     mem_byte_en <= req_m8[3:0];
                     mem_wr_data <= req_d64[31:0];
                  end
               end
            end
            StAcc1: begin
               if (!we_q) buf_lo_q <= mem_rd_data;
               if (cross_q) begin
                  state_q     <= StAcc2;
                  mem_addr    <= w1_q;
                  mem_wr_addr <= w1_q;
                  mem_byte_en <= be_hi_q;
                  mem_wr_data <= wd_hi_q;
               end else begin
                  state_q     <= StResp;
                  mem_wr_en   <= 1'b0;
                  mem_byte_en <= 4'b0;
                  rsp_valid   <= 1'b1;
                  rsp_err     <= 1'b0;
                  rsp_rdata   <= rsp_data_n;
               end
            end
            StAcc2: begin
               if (!we_q) buf_hi_q <= mem_rd_data[23:0];
               state_q     <= StResp;
               mem_wr_en   <= 1'b0;
               mem_byte_en <= 4'b0;
               rsp_valid   <= 1'b1;
               rsp_err     <= 1'b0;
               rsp_rdata   <= rsp_data_n;
            end
            default: begin
               state_q   <= StIdle;
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               rsp_rdata <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed vector table against a small byte-lane memory, plus
// hand-written reset and no-misalign sequences.
module tb_lsu_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic [31:0] mem_addr, mem_rd_data, mem_wr_addr, mem_wr_data;
   logic        mem_wr_en;
   logic [3:0]  mem_byte_en;

   logic        b_valid, b_ready, b_rsp_valid, b_rsp_err, b_wr_en;
   logic [31:0] b_rsp_rdata, b_mem_addr, b_wr_addr, b_wr_data;
   logic [31:0] b_rd_data = 32'h1234_5678;
   logic [3:0]  b_be;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   lsu_mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ALLOW_MISALIGNED(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en),
      .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_byte_en(mem_byte_en)
   );

   lsu_mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ALLOW_MISALIGNED(1'b0)) u_dut_nomis (
      .clk(clk), .rst_n(rst_n),
      .req_valid(b_valid), .req_ready(b_ready), .req_we(req_we), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
      .mem_addr(b_mem_addr), .mem_rd_data(b_rd_data), .mem_wr_en(b_wr_en),
      .mem_wr_addr(b_wr_addr), .mem_wr_data(b_wr_data), .mem_byte_en(b_be)
   );

   // 4 KiB window of byte-lane memory, aliased on address bits [11:2]
   bit [31:0] mem [1024];
   assign mem_rd_data = mem[mem_addr[11:2]];
   always @(posedge clk) begin
      if (mem_wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_byte_en[b]) mem[mem_wr_addr[11:2]][8*b +: 8] <= mem_wr_data[8*b +: 8];
         end
      end
   end

   typedef struct {
      string       name;
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          lat;
      logic        err;
      logic [31:0] rdata;
      logic [31:0] w1;
      logic [3:0]  be1;
      logic [31:0] wd1;
      logic [31:0] w2;
      logic [3:0]  be2;
      logic [31:0] wd2;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string name, input logic we, input logic [1:0] size,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                      input int lat, input logic err, input logic [31:0] rdata,
                      input logic [31:0] w1, input logic [3:0] be1, input logic [31:0] wd1,
                      input logic [31:0] w2, input logic [3:0] be2, input logic [31:0] wd2);
      vec_t v;
      v.name = name; v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.lat = lat; v.err = err; v.rdata = rdata;
      v.w1 = w1; v.be1 = be1; v.wd1 = wd1; v.w2 = w2; v.be2 = be2; v.wd2 = wd2;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int seen_lat = 0;
      int pulses   = 0;
      @(negedge clk);
      check({v.name, "_ready"}, {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
      req_addr = v.addr; req_wdata = v.wdata;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) req_valid = 1'b0;
         if (rsp_valid) begin
            pulses++;
            if (seen_lat == 0) begin
               seen_lat = k;
               check({v.name, "_rdata"}, rsp_rdata, v.rdata);
               check({v.name, "_err"}, {31'b0, rsp_err}, {31'b0, v.err});
            end
         end
         if (k == 1 && v.err) begin
            check({v.name, "_err_no_wr"}, {31'b0, mem_wr_en}, 32'd0);
            check({v.name, "_err_no_be"}, {28'b0, mem_byte_en}, 32'd0);
         end
         if (k == 1 && !v.err) begin
            check({v.name, "_a1_addr"}, mem_addr, v.w1);
            check({v.name, "_a1_waddr"}, mem_wr_addr, v.w1);
            check({v.name, "_a1_be"}, {28'b0, mem_byte_en}, {28'b0, v.be1});
            check({v.name, "_a1_we"}, {31'b0, mem_wr_en}, {31'b0, v.we});
            if (v.we) check({v.name, "_a1_wdata"}, mem_wr_data, v.wd1);
         end
         if (k == 2 && v.lat == 3) begin
            check({v.name, "_a2_addr"}, mem_addr, v.w2);
            check({v.name, "_a2_be"}, {28'b0, mem_byte_en}, {28'b0, v.be2});
            if (v.we) check({v.name, "_a2_wdata"}, mem_wr_data, v.wd2);
         end
      end
      check({v.name, "_latency"}, seen_lat, v.lat);
      check({v.name, "_pulses"}, pulses, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int bad;
      rst_n = 1'b0; req_valid = 1'b0; b_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

      //   name           we size   u addr          wdata         lat err rdata
      //   w1            be1      wd1           w2            be2      wd2
      add("st_word",      1, 2'b10, 0, 32'h100,      32'hDEADBEEF, 2, 0, 32'h0,
          32'h100,      4'b1111, 32'hDEADBEEF, 32'h0,        4'b0000, 32'h0);
      add("ld_word",      0, 2'b10, 0, 32'h100,      32'h0,        2, 0, 32'hDEADBEEF,
          32'h100,      4'b1111, 32'h0,        32'h0,        4'b0000, 32'h0);
      add("st_byte",      1, 2'b00, 0, 32'h203,      32'h80,       2, 0, 32'h0,
          32'h200,      4'b1000, 32'h80000000, 32'h0,        4'b0000, 32'h0);
      add("ld_byte_s",    0, 2'b00, 0, 32'h203,      32'h0,        2, 0, 32'hFFFFFF80,
          32'h200,      4'b1000, 32'h0,        32'h0,        4'b0000, 32'h0);
      add("ld_byte_u",    0, 2'b00, 1, 32'h203,      32'h0,        2, 0, 32'h00000080,
          32'h200,      4'b1000, 32'h0,        32'h0,        4'b0000, 32'h0);
      add("ld_half_s",    0, 2'b01, 0, 32'h202,      32'h0,        2, 0, 32'hFFFF8000,
          32'h200,      4'b1100, 32'h0,        32'h0,        4'b0000, 32'h0);
      add("ld_half_u",    0, 2'b01, 1, 32'h202,      32'h0,        2, 0, 32'h00008000,
          32'h200,      4'b1100, 32'h0,        32'h0,        4'b0000, 32'h0);
      add("st_split",     1, 2'b10, 0, 32'h101,      32'h11223344, 3, 0, 32'h0,
          32'h100,      4'b1110, 32'h22334400, 32'h104,      4'b0001, 32'h00000011);
      add("ld_split",     0, 2'b10, 0, 32'h101,      32'h0,        3, 0, 32'h11223344,
          32'h100,      4'b1110, 32'h0,        32'h104,      4'b0001, 32'h0);
      add("ld_half_x",    0, 2'b01, 0, 32'h103,      32'h0,        3, 0, 32'h00001122,
          32'h100,      4'b1000, 32'h0,        32'h104,      4'b0001, 32'h0);
      add("st_wrap",      1, 2'b01, 0, 32'hFFFFFFFF, 32'h0000ABCD, 3, 0, 32'h0,
          32'hFFFFFFFC, 4'b1000, 32'hCD000000, 32'h0,        4'b0001, 32'h000000AB);
      add("ld_wrap_u",    0, 2'b01, 1, 32'hFFFFFFFF, 32'h0,        3, 0, 32'h0000ABCD,
          32'hFFFFFFFC, 4'b1000, 32'h0,        32'h0,        4'b0001, 32'h0);
      add("ld_wrap_s",    0, 2'b01, 0, 32'hFFFFFFFF, 32'h0,        3, 0, 32'hFFFFABCD,
          32'hFFFFFFFC, 4'b1000, 32'h0,        32'h0,        4'b0001, 32'h0);
      add("st_byte1",     1, 2'b00, 0, 32'h001,      32'hFFFFFF7F, 2, 0, 32'h0,
          32'h0,        4'b0010, 32'hFFFF7F00, 32'h0,        4'b0000, 32'h0);
      add("ld_byte1",     0, 2'b00, 0, 32'h001,      32'h0,        2, 0, 32'h0000007F,
          32'h0,        4'b0010, 32'h0,        32'h0,        4'b0000, 32'h0);
      add("ld_word0",     0, 2'b10, 0, 32'h000,      32'h0,        2, 0, 32'h00007FAB,
          32'h0,        4'b1111, 32'h0,        32'h0,        4'b0000, 32'h0);
      add("ld_bad_size",  0, 2'b11, 0, 32'h100,      32'h0,        1, 1, 32'h0,
          32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0);
      add("st_bad_size",  1, 2'b11, 0, 32'h100,      32'hFFFFFFFF, 1, 1, 32'h0,
          32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0);
      add("ld_after_err", 0, 2'b10, 0, 32'h100,      32'h0,        2, 0, 32'h223344EF,
          32'h100,      4'b1111, 32'h0,        32'h0,        4'b0000, 32'h0);

      #1;
      check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_wr_en", {31'b0, mem_wr_en}, 32'd0);
      check("rst_byte_en", {28'b0, mem_byte_en}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_ready", {31'b0, req_ready}, 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // No-misalign instance: split store rejected in one cycle, in-word accesses still work
      @(negedge clk);
      b_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h101; req_wdata = 32'h11223344;
      bad = 0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (k == 1) b_valid = 1'b0;
         if (b_wr_en || b_be != 4'b0) bad++;
         if (k == 1) begin
            check("nomis_rsp_valid", {31'b0, b_rsp_valid}, 32'd1);
            check("nomis_rsp_err", {31'b0, b_rsp_err}, 32'd1);
            check("nomis_rsp_rdata", b_rsp_rdata, 32'd0);
            check("nomis_wr_data", b_wr_data, 32'd0);
         end
         if (k == 2) check("nomis_pulse_end", {31'b0, b_rsp_valid}, 32'd0);
      end
      check("nomis_no_access", bad, 0);

      b_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h10;
      @(negedge clk);
      b_valid = 1'b0;
      check("nomis_ld_addr", b_mem_addr, 32'h10);
      check("nomis_ld_waddr", b_wr_addr, 32'h10);
      check("nomis_ld_be", {28'b0, b_be}, 32'hF);
      check("nomis_ld_early", {31'b0, b_rsp_valid}, 32'd0);
      @(negedge clk);
      check("nomis_ld_valid", {31'b0, b_rsp_valid}, 32'd1);
      check("nomis_ld_rdata", b_rsp_rdata, 32'h12345678);
      check("nomis_ld_err", {31'b0, b_rsp_err}, 32'd0);

      repeat (2) @(negedge clk);
      b_valid = 1'b1; req_size = 2'b01; req_addr = 32'h101;
      @(negedge clk);
      b_valid = 1'b0;
      @(negedge clk);
      check("nomis_half_valid", {31'b0, b_rsp_valid}, 32'd1);
      check("nomis_half_rdata", b_rsp_rdata, 32'h00003456);
      check("nomis_half_err", {31'b0, b_rsp_err}, 32'd0);

      // Reset in the middle of ACC1 of a store: abandoned, nothing written
      repeat (2) @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h300;
      req_wdata = 32'h55AA55AA;
      @(negedge clk);
      req_valid = 1'b0;
      check("mid_rst_acc1_we", {31'b0, mem_wr_en}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_wr_en", {31'b0, mem_wr_en}, 32'd0);
      check("mid_rst_byte_en", {28'b0, mem_byte_en}, 32'd0);
      check("mid_rst_mem_addr", mem_addr, 32'd0);
      check("mid_rst_wr_addr", mem_wr_addr, 32'd0);
      check("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("mid_rst_ready", {31'b0, req_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (mem_wr_en || rsp_valid) bad++;
      end
      check("mid_rst_quiet", bad, 0);
      check("mid_rst_mem_untouched", mem[32'h300 >> 2], 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
